ro_rsa_sequencer: RTL and testbench

- Run controller for one side-channel capture. Starts ring-oscillator sampling and the DMA write channel, fires the RSA core after a programmable delay, and measures RSA latency.
- Stops sampling a programmable number of cycles after RSA completes, then waits for the DMA write to drain and reports done plus status to the MMIO memory map.
- Sits in the AFU between the memory map (go, config, done) and ro_top, RSACypher and the DMA write channel.

---
 rtl/ro_rsa_sequencer.sv | 167 ++++++++++++++++
 tb/tb_ro_rsa_sequencer.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/ro_rsa_sequencer.sv
// Run controller for one side-channel capture: starts RO sampling and DMA, fires the
// RSA core after a delay, times the RSA run, then stops sampling and waits for the drain.
module ro_rsa_sequencer #(
   parameter int CFG_WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 go,
   input  logic [CFG_WIDTH-1:0] trigger_delay,
   input  logic [CFG_WIDTH-1:0] tail_cycles,
   input  logic [CFG_WIDTH-1:0] rsa_timeout,
   input  logic                 rsa_ready,
   input  logic                 wr_done,
   output logic                 ro_go,
   output logic                 rsa_go,
   output logic                 ro_stop,
   output logic                 busy,
   output logic                 done,
   output logic [CFG_WIDTH-1:0] rsa_cycles,
   output logic [1:0]           status
);
   typedef enum logic [2:0] {
      IDLE, DELAY, FIRE, WAIT_BUSY, WAIT_DONE, TAIL, DRAIN, FINISH
   } state_t;

   localparam logic [CFG_WIDTH-1:0] ONE = CFG_WIDTH'(1);

   state_t               state_reg, state_next;
   logic [CFG_WIDTH-1:0] count_reg, count_next;
   logic [CFG_WIDTH-1:0] cycles_reg, cycles_next, cycles_inc;
   logic [CFG_WIDTH-1:0] delay_reg, tail_reg, timeout_reg;
   logic [1:0]           status_reg, status_next;
   logic                 ro_go_reg, ro_go_next;
   logic                 rsa_go_reg, rsa_go_next;
   logic                 ro_stop_reg, ro_stop_next;
   logic                 busy_reg, busy_next;
   logic                 done_reg, done_next;
   logic                 accept, delay_hit, tail_hit, timed_out, in_run;

   assign accept     = go && (state_reg == IDLE || state_reg == FINISH);
   assign delay_hit  = (count_reg == delay_reg);
   assign tail_hit   = (count_reg == tail_reg);
   assign timed_out  = (timeout_reg != '0) && (cycles_reg == timeout_reg);
   assign cycles_inc = (&cycles_reg) ? cycles_reg : cycles_reg + ONE;
   assign in_run     = state_reg inside {DELAY, FIRE, WAIT_BUSY, WAIT_DONE};

   always_ff @(posedge clk) begin
      if (rst)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // The delay compare fires rsa_go directly when the core is already idle, so that
   // rsa_go lands trigger_delay+1 cycles after ro_go; FIRE only holds a deferred trigger.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE, FINISH: if (go) state_next = DELAY;
         DELAY:        if (delay_hit) state_next = rsa_ready ? WAIT_BUSY : FIRE;
         FIRE:         if (rsa_ready) state_next = WAIT_BUSY;
         WAIT_BUSY: begin
            if (timed_out)       state_next = TAIL;
            else if (!rsa_ready) state_next = WAIT_DONE;
         end
         WAIT_DONE:    if (timed_out || rsa_ready) state_next = TAIL;
         TAIL:         if (tail_hit) state_next = DRAIN;
         DRAIN:        if (wr_done) state_next = FINISH;
         default:      state_next = IDLE;
      endcase
   end

   always_comb begin
      count_next   = count_reg;
      cycles_next  = cycles_reg;
      status_next  = status_reg;
      done_next    = done_reg;
      ro_go_next   = 1'b0;
      rsa_go_next  = 1'b0;
      ro_stop_next = 1'b0;
      busy_next    = !(state_next inside {IDLE, FINISH});
      if (in_run && wr_done)
         status_next[1] = 1'b1;
      case (state_reg)
         IDLE, FINISH: begin
            if (go) begin
               count_next  = '0;
               cycles_next = '0;
               status_next = '0;
               done_next   = 1'b0;
               ro_go_next  = 1'b1;
            end
         end
         DELAY: begin
            if (!delay_hit) begin
               count_next = count_reg + ONE;
            end else if (rsa_ready) begin
               rsa_go_next = 1'b1;
               cycles_next = '0;
            end
         end
         FIRE: begin
            if (rsa_ready) begin
               rsa_go_next = 1'b1;
               cycles_next = '0;
            end
         end
         WAIT_BUSY, WAIT_DONE: begin
            // The cycle that exits to TAIL is not counted, freezing rsa_cycles.
            if (timed_out) begin
               status_next[0] = 1'b1;
               count_next     = '0;
            end else if (state_reg == WAIT_DONE && rsa_ready) begin
               count_next = '0;
            end else begin
               cycles_next = cycles_inc;
            end
         end
         TAIL: begin
            if (tail_hit)
               ro_stop_next = 1'b1;
            else
               count_next = count_reg + ONE;
         end
         DRAIN: if (wr_done) done_next = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         count_reg   <= '0;
         cycles_reg  <= '0;
         status_reg  <= '0;
         delay_reg   <= '0;
         tail_reg    <= '0;
         timeout_reg <= '0;
         ro_go_reg   <= 1'b0;
         rsa_go_reg  <= 1'b0;
         ro_stop_reg <= 1'b0;
         busy_reg    <= 1'b0;
         done_reg    <= 1'b0;
      end else begin
         count_reg   <= count_next;
         cycles_reg  <= cycles_next;
         status_reg  <= status_next;
         ro_go_reg   <= ro_go_next;
         rsa_go_reg  <= rsa_go_next;
         ro_stop_reg <= ro_stop_next;
         busy_reg    <= busy_next;
         done_reg    <= done_next;
         if (accept) begin
            delay_reg   <= trigger_delay;
            tail_reg    <= tail_cycles;
            timeout_reg <= rsa_timeout;
         end
      end
   end

   assign ro_go      = ro_go_reg;
   assign rsa_go     = rsa_go_reg;
   assign ro_stop    = ro_stop_reg;
   assign busy       = busy_reg;
   assign done       = done_reg;
   assign rsa_cycles = cycles_reg;
   assign status     = status_reg;
endmodule

// File: tb/tb_ro_rsa_sequencer.sv
// Bench for ro_rsa_sequencer: directed table, randomized runs and a mid-run reset,
// judged against a reference that derives the run timeline from logged input waveforms.
module tb_ro_rsa_sequencer;
   localparam int W     = 32;
   localparam int N     = 16384;
   localparam int NEVER = 1000000;

   logic         clk = 1'b0;
   logic         rst, go, rsa_ready, wr_done;
   logic [W-1:0] trigger_delay, tail_cycles, rsa_timeout, rsa_cycles;
   logic         ro_go, rsa_go, ro_stop, busy, done;
   logic [1:0]   status;

   ro_rsa_sequencer #(.CFG_WIDTH(W)) dut (
      .clk(clk), .rst(rst), .go(go),
      .trigger_delay(trigger_delay), .tail_cycles(tail_cycles), .rsa_timeout(rsa_timeout),
      .rsa_ready(rsa_ready), .wr_done(wr_done),
      .ro_go(ro_go), .rsa_go(rsa_go), .ro_stop(ro_stop), .busy(busy), .done(done),
      .rsa_cycles(rsa_cycles), .status(status)
   );

   always #5 clk = ~clk;

   typedef struct {
      int td, tl, to, lat, wrlat, bu, early, extra;
      int e_rsa_off, e_rc, e_stop_off, e_done_off, e_st;
   } vec_t;

   vec_t tbl[7];
   int   vectors = 0, miscompares = 0;
   int   cyc = 0;
   int   cur_td = 0, cur_tl = 0, cur_to = 0, cur_lat = 1, cur_wrlat = 0;
   int   rsa_low_at = -1, rsa_high_at = -1, wr_at = -1, early_at = -1, lo_start = -1, lo_end = -1;
   bit   rogo_l[N], rsago_l[N], stop_l[N], done_l[N], busy_l[N], rdy_l[N], wrd_l[N];

   task automatic chk(input string nm, input int act, input int exp_v);
      vectors++;
      if (act !== exp_v) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
      end
   endtask

   // One clock: log outputs of the new cycle, then drive that cycle's inputs.
   task automatic tick(input bit go_v, input bit rst_v);
      bit r, w;
      @(posedge clk); #1;
      cyc++;
      if (cyc >= N) begin
         $display("FAIL cycle_log: bench ran past %0d cycles", N);
         $fatal(1, "log overflow");
      end
      rogo_l[cyc] = ro_go; rsago_l[cyc] = rsa_go; stop_l[cyc] = ro_stop;
      done_l[cyc] = done;  busy_l[cyc] = busy;
      if (rsa_go) begin
         rsa_low_at  = cyc + 1;
         rsa_high_at = cyc + 1 + cur_lat;
      end
      if (ro_stop) wr_at = cyc + cur_wrlat;
      r = 1'b1;
      if (cyc >= lo_start && cyc < lo_end) r = 1'b0;
      if (rsa_low_at >= 0 && cyc >= rsa_low_at && cyc < rsa_high_at) r = 1'b0;
      w = (wr_at >= 0 && cyc >= wr_at) || (early_at >= 0 && cyc >= early_at);
      rsa_ready = r;  wr_done = w;
      rdy_l[cyc] = r; wrd_l[cyc] = w;
      go = go_v; rst = rst_v;
      if (go_v) begin
         trigger_delay = cur_td; tail_cycles = cur_tl; rsa_timeout = cur_to;
      end else begin
         trigger_delay = $urandom(); tail_cycles = $urandom(); rsa_timeout = $urandom();
      end
   endtask

   function automatic void scan(input int sel, input int from, input int upto,
                                output int first, output int cnt);
      bit v;
      first = -1; cnt = 0;
      for (int c = from; c <= upto; c++) begin
         case (sel)
            0:       v = rogo_l[c];
            1:       v = rsago_l[c];
            2:       v = stop_l[c];
            default: v = done_l[c];
         endcase
         if (v) begin
            if (first < 0) first = c;
            cnt++;
         end
      end
   endfunction

   // Timeline of a run accepted at cycle a, from the rules and the logged inputs.
   function automatic void model(input int a, input int td, input int tl, input int to,
                                 input int endc, output int t, output int g, output int s,
                                 output int dn, output int rc, output int st);
      int d, r, te;
      t = a + 1; g = -1; s = -1; dn = -1; rc = -1; st = -1;
      for (int c = t + td + 1; c <= endc && g < 0; c++) if (rdy_l[c-1]) g = c;
      if (g < 0) return;
      d = -1; r = -1;
      for (int c = g; c <= endc && d < 0; c++) if (!rdy_l[c]) d = c;
      if (d >= 0) for (int c = d + 1; c <= endc && r < 0; c++) if (rdy_l[c]) r = c;
      if (to != 0 && (r < 0 || r - g >= to)) begin
         te = g + to + 1; rc = to; st = 1;
      end else if (r < 0) begin
         return;
      end else begin
         te = r + 1; rc = r - g; st = 0;
      end
      for (int c = t; c < te && c <= endc; c++) if (wrd_l[c]) st = st | 2;
      s = te + tl + 1;
      for (int c = s; c <= endc && dn < 0; c++) if (wrd_l[c]) dn = c + 1;
   endfunction

   task automatic run(input string nm, input vec_t v, output int g_off, output int rc_o,
                      output int s_off, output int d_off, output int st_o);
      int a, t, endc, fr, nr, fg, ng, fs, ns, fd, nd, bad;
      int mt, mg, ms, mdn, mrc, mst;
      cur_td = v.td; cur_tl = v.tl; cur_to = v.to; cur_lat = v.lat; cur_wrlat = v.wrlat;
      rsa_low_at = -1; rsa_high_at = -1; wr_at = -1; early_at = -1; lo_start = -1; lo_end = -1;
      tick(1'b0, 1'b0);
      a = cyc + 1; t = a + 1;
      lo_start = t; lo_end = t + v.bu;
      if (v.early >= 0) early_at = t + v.early;
      tick(1'b1, 1'b0);
      while (!(done_l[cyc] && cyc > t) && cyc < a + 2000)
         tick(v.extra >= 0 && cyc + 1 == t + v.extra, 1'b0);
      chk({nm, "_done_within_budget"}, int'(done_l[cyc]), 1);
      repeat (2) tick(1'b0, 1'b0);
      endc = cyc;
      model(a, v.td, v.tl, v.to, endc, mt, mg, ms, mdn, mrc, mst);
      scan(0, a + 1, endc, fr, nr);
      scan(1, a + 1, endc, fg, ng);
      scan(2, a + 1, endc, fs, ns);
      scan(3, t, endc, fd, nd);
      chk({nm, "_ro_go_cycle"}, fr, mt);
      chk({nm, "_ro_go_count"}, nr, 1);
      chk({nm, "_rsa_go_cycle"}, fg, mg);
      chk({nm, "_rsa_go_count"}, ng, 1);
      chk({nm, "_ro_stop_cycle"}, fs, ms);
      chk({nm, "_ro_stop_count"}, ns, 1);
      chk({nm, "_done_cycle"}, fd, mdn);
      chk({nm, "_rsa_cycles"}, int'(rsa_cycles), mrc);
      chk({nm, "_status"}, int'(status), mst);
      bad = 0;
      for (int c = t; c <= endc; c++)
         if (busy_l[c] != (c < mdn) || done_l[c] != (c >= mdn)) bad++;
      chk({nm, "_busy_done_profile"}, bad, 0);
      g_off = fg - fr; rc_o = int'(rsa_cycles); s_off = fs - fg; d_off = fd - fs;
      st_o = int'(status);
      $display("run %-6s td=%0d tl=%0d to=%0d: rsa_go@ro_go+%0d rsa_cycles=%0d ro_stop@rsa_go+%0d done@ro_stop+%0d status=%0d (%0d done cycles seen)",
               nm, v.td, v.tl, v.to, g_off, rc_o, s_off, d_off, st_o, nd);
   endtask

   task automatic apply_vec(input int i);
      int g_off, rc_o, s_off, d_off, st_o;
      run($sformatf("dir%0d", i), tbl[i], g_off, rc_o, s_off, d_off, st_o);
      chk($sformatf("dir%0d_rsa_go_offset", i), g_off, tbl[i].e_rsa_off);
      chk($sformatf("dir%0d_rsa_cycles", i), rc_o, tbl[i].e_rc);
      chk($sformatf("dir%0d_stop_offset", i), s_off, tbl[i].e_stop_off);
      chk($sformatf("dir%0d_done_offset", i), d_off, tbl[i].e_done_off);
      chk($sformatf("dir%0d_status", i), st_o, tbl[i].e_st);
   endtask

   initial begin
      vec_t rv;
      int   g_off, rc_o, s_off, d_off, st_o, c0, f, n;
      //          td tl to  lat    wrl bu early extra | rsa_off rc  stop done st
      tbl[0] = '{5, 3, 0,  100,   20, 0,  -1,  -1,     6,    101, 106, 21,  0}; // nominal
      tbl[1] = '{0, 0, 0,  10,    3,  0,  -1,  -1,     1,    11,  13,  4,   0}; // zero delays
      tbl[2] = '{2, 1, 0,  30,    5,  20, -1,  -1,     21,   31,  34,  6,   0}; // busy at fire
      tbl[3] = '{3, 2, 50, NEVER, 5,  0,  -1,  -1,     4,    50,  54,  6,   1}; // timeout
      tbl[4] = '{4, 2, 0,  60,    20, 0,  40,  2,      5,    61,  65,  1,   2}; // early wr_done, extra go
      tbl[5] = '{1, 0, 1,  100,   0,  0,  -1,  -1,     2,    1,   3,   1,   1}; // timeout of 1
      tbl[6] = '{0, 0, 12, 10,    2,  0,  -1,  -1,     1,    11,  13,  3,   0}; // completes just inside limit

      rst = 1'b1; go = 1'b0; rsa_ready = 1'b1; wr_done = 1'b0;
      trigger_delay = '0; tail_cycles = '0; rsa_timeout = '0;
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("reset_outputs", int'({ro_go, rsa_go, ro_stop, busy, done, status}), 0);
      chk("reset_rsa_cycles", int'(rsa_cycles), 0);

      for (int i = 0; i < 7; i++) apply_vec(i);

      // Reset during WAIT_DONE: everything clears next cycle and no ro_stop follows.
      cur_td = 3; cur_tl = 2; cur_to = 0; cur_lat = 100; cur_wrlat = 5;
      rsa_low_at = -1; rsa_high_at = -1; wr_at = -1; early_at = -1; lo_start = -1; lo_end = -1;
      tick(1'b0, 1'b0);
      tick(1'b1, 1'b0);
      repeat (20) tick(1'b0, 1'b0);
      chk("pre_reset_busy", int'(busy), 1);
      tick(1'b0, 1'b1);
      tick(1'b0, 1'b0);
      chk("midrun_reset_outputs", int'({ro_go, rsa_go, ro_stop, busy, done, status}), 0);
      chk("midrun_reset_rsa_cycles", int'(rsa_cycles), 0);
      c0 = cyc;
      repeat (150) tick(1'b0, 1'b0);
      scan(2, c0, cyc, f, n);
      chk("no_stop_after_reset", n, 0);
      $display("run reset: outputs cleared at cycle %0d, %0d ro_stop pulses afterwards", c0, n);
      apply_vec(0);

      for (int k = 0; k < 25; k++) begin
         rv.td    = int'($urandom_range(0, 8));
         rv.tl    = int'($urandom_range(0, 8));
         rv.to    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 60));
         rv.lat   = int'($urandom_range(1, 80));
         if (rv.to != 0 && $urandom_range(0, 3) == 0) rv.lat = NEVER;
         rv.wrlat = int'($urandom_range(0, 30));
         rv.bu    = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 25));
         rv.early = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 40)) : -1;
         rv.extra = ($urandom_range(0, 9) < 3) ? int'($urandom_range(0, rv.td)) : -1;
         rv.e_rsa_off = 0; rv.e_rc = 0; rv.e_stop_off = 0; rv.e_done_off = 0; rv.e_st = 0;
         run($sformatf("rnd%0d", k), rv, g_off, rc_o, s_off, d_off, st_o);
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
